// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - command codes, FSM states and sizing helper for spi_ram_burst
package spi_ram_pkg;

    typedef enum logic [1:0] {
        CMD_WADDR = 2'b00,
        CMD_WDATA = 2'b01,
        CMD_RADDR = 2'b10,
        CMD_RDATA = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC_W,
        ST_ACC_R,
        ST_RESP
    } state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/spi_ram_burst_ram_sdp.sv
// rtl/spi_ram_burst_ram_sdp.sv - simple dual-port synchronous word storage, registered read, no reset
module ram_sdp #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/spi_ram_burst.sv
// rtl/spi_ram_burst.sv - command-driven word RAM behind an SPI slave with burst pointers and backpressure
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 8,
    parameter int AUTO_INC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic [WORD_SIZE+1:0] din,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [WORD_SIZE-1:0] dout,
    output logic                 addr_err
);

    localparam int ADDR_BEATS = ceil_div(ADDR_SIZE, WORD_SIZE);
    localparam int DIN_WIDTH  = WORD_SIZE + 2;
    localparam int ACC_BITS   = ADDR_BEATS * WORD_SIZE;
    localparam int CNT_W      = $clog2(ADDR_BEATS + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(ADDR_BEATS - 1);
    localparam logic [ADDR_SIZE:0]   DEPTH_X  = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_PTR = ADDR_SIZE'(MEM_DEPTH - 1);

    state_e                 state_q;
    logic [ADDR_SIZE-1:0]   wr_ptr_q, rd_ptr_q;
    logic [ACC_BITS-1:0]    acc_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   tx_valid_q, addr_err_q, dsel_q;

    cmd_e                   cmd;
    logic [WORD_SIZE-1:0]   payload;
    logic                   accept, cont, wr_oor, rd_oor;
    logic [ACC_BITS-1:0]    acc_start, acc_shift;
    logic [WORD_SIZE-1:0]   ram_rdata;

    assign cmd       = cmd_e'(din[DIN_WIDTH-1:DIN_WIDTH-2]);
    assign payload   = din[WORD_SIZE-1:0];
    assign rx_ready  = ~tx_valid_q | tx_ready;
    assign accept    = rx_valid & rx_ready;
    assign wr_oor    = {1'b0, wr_ptr_q} >= DEPTH_X;
    assign rd_oor    = {1'b0, rd_ptr_q} >= DEPTH_X;
    assign acc_start = ACC_BITS'(payload);
    assign acc_shift = (acc_q << WORD_SIZE) | acc_start;
    // A beat only continues a load if it matches the kind being collected.
    assign cont      = (state_q == ST_ACC_W && cmd == CMD_WADDR) ||
                       (state_q == ST_ACC_R && cmd == CMD_RADDR);

    assign tx_valid  = tx_valid_q;
    assign addr_err  = addr_err_q;
    assign dout      = dsel_q ? ram_rdata : '0;

    function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
        if (AUTO_INC == 0) return p;
        if ({1'b0, p} >= DEPTH_X || p == LAST_PTR) return '0;
        return p + 1'b1;
    endfunction

    ram_sdp #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_SIZE),
        .DW    (WORD_SIZE)
    ) u_ram (
        .clk   (clk),
        .we    (accept && cmd == CMD_WDATA && !wr_oor),
        .waddr (wr_ptr_q),
        .wdata (payload),
        .re    (accept && cmd == CMD_RDATA && !rd_oor),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            dsel_q     <= 1'b0;
        end else begin
            addr_err_q <= 1'b0;
            if (tx_valid_q && tx_ready) begin
                tx_valid_q <= 1'b0;
                state_q    <= ST_IDLE;
            end
            if (accept) begin
                if (cont) begin
                    acc_q <= acc_shift;
                    if (cnt_q == CNT_LAST) begin
                        if (state_q == ST_ACC_W) wr_ptr_q <= acc_shift[ADDR_SIZE-1:0];
                        else                     rd_ptr_q <= acc_shift[ADDR_SIZE-1:0];
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                    case (cmd)
                        CMD_WADDR, CMD_RADDR: begin
                            acc_q <= acc_start;
                            if (ADDR_BEATS == 1) begin
                                if (cmd == CMD_WADDR) wr_ptr_q <= acc_start[ADDR_SIZE-1:0];
                                else                  rd_ptr_q <= acc_start[ADDR_SIZE-1:0];
                            end else begin
                                cnt_q   <= CNT_W'(1);
                                state_q <= (cmd == CMD_WADDR) ? ST_ACC_W : ST_ACC_R;
                            end
                        end
                        CMD_WDATA: begin
                            wr_ptr_q   <= next_ptr(wr_ptr_q);
                            addr_err_q <= wr_oor;
                        end
                        CMD_RDATA: begin
                            rd_ptr_q   <= next_ptr(rd_ptr_q);
                            addr_err_q <= rd_oor;
                            dsel_q     <= !rd_oor;
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_RESP;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// tb/tb_spi_ram_burst.sv - directed self-checking bench for spi_ram_burst
module tb_spi_ram_burst;

    localparam logic [1:0] WADDR = 2'b00, WDATA = 2'b01, RADDR = 2'b10, RDATA = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [9:0] din = '0;
    logic       tx_ready = 1'b1;
    logic       rx_ready, tx_valid, addr_err;
    logic [7:0] dout;
    logic       rx_ready_s, tx_valid_s, addr_err_s;
    logic [7:0] dout_s;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    spi_ram_burst dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_ready(rx_ready), .din(din),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .dout(dout), .addr_err(addr_err)
    );

    spi_ram_burst #(.MEM_DEPTH(1000)) dut_s (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_ready(rx_ready_s), .din(din),
        .tx_valid(tx_valid_s), .tx_ready(tx_ready), .dout(dout_s), .addr_err(addr_err_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [1:0] c, input logic [7:0] p);
        @(negedge clk);
        rx_valid = 1'b1;
        din = {c, p};
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] exp);
        sb.push_back(exp);
        beat(RDATA, 8'h00);
        chk("rd_tx_valid", 32'(tx_valid), 32'd1);
        chk("rd_dout", 32'(dout), 32'(exp));
    endtask

    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_unexpected observed=%0h expected=none", dout);
            end else begin
                chk("sb_dout", 32'(dout), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);

        beat(WADDR, 8'h01); beat(WADDR, 8'h23);
        beat(WDATA, 8'hA5); beat(WDATA, 8'h5A);
        beat(RADDR, 8'h01); beat(RADDR, 8'h23);
        rd(8'hA5);
        rd(8'h5A);
        chk("no_addr_err", 32'(addr_err), 32'd0);

        beat(WADDR, 8'h03); beat(WADDR, 8'hFF);
        beat(WDATA, 8'h11); beat(WDATA, 8'h22);
        beat(RADDR, 8'h03); beat(RADDR, 8'hFF);
        rd(8'h11);
        rd(8'h22);

        beat(RADDR, 8'h01); beat(RADDR, 8'h23);
        @(negedge clk) tx_ready = 1'b0;
        rd(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_tx_valid", 32'(tx_valid), 32'd1);
            chk("hold_dout", 32'(dout), 32'hA5);
            chk("hold_rx_ready", 32'(rx_ready), 32'd0);
        end
        @(posedge clk);
        #1 tx_ready = 1'b1;
        @(posedge clk);
        #1 chk("drain_tx_valid", 32'(tx_valid), 32'd0);

        beat(WADDR, 8'h00); beat(WADDR, 8'h40);
        beat(WADDR, 8'h02);
        beat(WDATA, 8'h77); beat(WDATA, 8'h88);
        beat(RADDR, 8'h00); beat(RADDR, 8'h40);
        rd(8'h77);
        rd(8'h88);

        beat(WADDR, 8'h03); beat(WADDR, 8'hF0);
        beat(WDATA, 8'h3C); beat(WDATA, 8'h4D);
        beat(RADDR, 8'h03); beat(RADDR, 8'hF0);
        rd(8'h3C);
        chk("oor_tx_valid", 32'(tx_valid_s), 32'd1);
        chk("oor_dout", 32'(dout_s), 32'd0);
        chk("oor_addr_err", 32'(addr_err_s), 32'd1);
        rd(8'h4D);
        chk("oor_err_pulse", 32'(addr_err_s), 32'd0);
        chk("oor_wrap_dout", 32'(dout_s), 32'h4D);

        beat(WADDR, 8'h01);
        @(negedge clk) rst_n = 1'b0;
        #1 chk("rst_accw_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        beat(WADDR, 8'h00); beat(WADDR, 8'h40);
        beat(WDATA, 8'h99);
        beat(RADDR, 8'h00); beat(RADDR, 8'h40);
        rd(8'h99);

        beat(RADDR, 8'h01); beat(RADDR, 8'h23);
        @(negedge clk) tx_ready = 1'b0;
        beat(RDATA, 8'h00);
        chk("resp_tx_valid", 32'(tx_valid), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("rst_resp_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_resp_dout", 32'(dout), 32'd0);
        chk("rst_resp_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        tx_ready = 1'b1;
        beat(RADDR, 8'h01); beat(RADDR, 8'h23);
        rd(8'hA5);
        beat(RADDR, 8'h03); beat(RADDR, 8'hFF);
        rd(8'h11);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
